// File: rtl/ble_tx_pkg.sv
// Shared types and constants for the BLE transmit scheduler: FSM states,
// requester indices and the heartbeat byte.
package ble_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_e;

    localparam int         NUM_REQ  = 3;
    localparam logic [7:0] HB_BYTE  = 8'h48;

    localparam logic [1:0] AUTH_ACK = 2'd0;
    localparam logic [1:0] TELEM    = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    // Successor of a requester index in the round-robin ring (mod NUM_REQ).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational round-robin arbiter: picks the first pending requester
// at or after ptr, returning a valid flag, a one-hot select and its index.
module tx_rr_pick
    import ble_tx_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] sel,
    output logic [1:0]         index
);

    logic [1:0] cand_s;

    // Walk the ring once starting at ptr; the first pending candidate wins.
    always_comb begin
        valid  = 1'b0;
        sel    = 3'b000;
        index  = 2'd0;
        cand_s = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                sel   = 3'b001 << cand_s;
                index = cand_s;
            end else begin
                valid = valid;
            end
            cand_s = rr_next(cand_s);
        end
    end

endmodule

// File: rtl/ble_tx_sched.sv
// BLE transmit scheduler: round-robin arbitration of three byte sources onto
// one UART_tx. Optional heartbeat source enabled by macro BLE_HEARTBEAT_EN.
module ble_tx_sched
    import ble_tx_pkg::*;
#(
    parameter int HB_PERIOD = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [7:0]         data0,
    input  logic [7:0]         data1,
    input  logic [7:0]         data2,
    input  logic               pwr_up,
    input  logic               tx_done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               trmt,
    output logic [7:0]         tx_data
);

    tx_state_e          state_r;
    tx_state_e          state_nxt_s;
    logic [1:0]         ptr_r;
    logic [1:0]         idx_r;
    logic               hb_r;
    logic [7:0]         tx_data_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] done_r;
    logic               trmt_r;

    logic               pick_valid_s;
    logic [NUM_REQ-1:0] pick_sel_s;
    logic [1:0]         pick_index_s;
    logic [7:0]         pick_byte_s;
    logic               start_req_s;
    logic               start_hb_s;
    logic               hb_fire_s;

    tx_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .sel   (pick_sel_s),
        .index (pick_index_s)
    );

    // Byte of the requester chosen by the arbiter.
    always_comb begin
        case (pick_index_s)
            AUTH_ACK: pick_byte_s = data0;
            TELEM:    pick_byte_s = data1;
            FAULT:    pick_byte_s = data2;
            default:  pick_byte_s = 8'h00;
        endcase
    end

`ifdef BLE_HEARTBEAT_EN
    localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

    logic [HB_W-1:0] hb_cnt_r;

    // Heartbeat only fills otherwise idle time, so any request pre-empts it.
    assign hb_fire_s = (state_r == ST_IDLE) && pwr_up && (req == 3'b000) &&
                       (hb_cnt_r == HB_W'(HB_PERIOD - 1));

    // Idle-time counter towards the next heartbeat byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_r <= '0;
        end else if (!pwr_up || start_req_s || hb_fire_s) begin
            hb_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && (req == 3'b000)) begin
            hb_cnt_r <= hb_cnt_r + HB_W'(1);
        end
    end
`else
    localparam int unused_hb_period = HB_PERIOD;
    logic          unused_pwr_up_s;

    assign unused_pwr_up_s = pwr_up;
    assign hb_fire_s       = 1'b0;
`endif

    // Next-state decode; requesters always win over the heartbeat.
    always_comb begin
        state_nxt_s = state_r;
        start_req_s = 1'b0;
        start_hb_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ST_SEND;
                    start_req_s = 1'b1;
                end else if (hb_fire_s) begin
                    state_nxt_s = ST_SEND;
                    start_hb_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, arbitration pointer, latched transfer and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            idx_r     <= 2'd0;
            hb_r      <= 1'b0;
            tx_data_r <= 8'h00;
            gnt_r     <= 3'b000;
            done_r    <= 3'b000;
            trmt_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            trmt_r  <= start_req_s | start_hb_s;
            gnt_r   <= start_req_s ? pick_sel_s : 3'b000;
            done_r  <= ((state_r == ST_WAIT) && tx_done && !hb_r) ?
                       (3'b001 << idx_r) : 3'b000;
            if (start_req_s) begin
                idx_r     <= pick_index_s;
                hb_r      <= 1'b0;
                tx_data_r <= pick_byte_s;
                ptr_r     <= rr_next(pick_index_s);
            end else if (start_hb_s) begin
                hb_r      <= 1'b1;
                tx_data_r <= HB_BYTE;
            end
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign trmt    = trmt_r;
    assign tx_data = tx_data_r;

endmodule
